cond_select_pipe: RTL and testbench

Parametrised, pipelined successor to the 4-to-2 condition selector in the 32-bit MIPS datapath. Takes a qualifying enable (R-type / compare-valid) plus NUM_SRC one-hot condition flags (gt/eq/lt/… from the ALU comparator), priority-encodes them into a writeback-mux select, and delivers the result through a 2-entry valid/ready buffer. Adds multi-hot flag detection with a saturating error counter. Sits between the ALU flag outputs and the writeback select mux.

---
 rtl/cond_select_pipe.sv | 125 ++++++++++++
 tb/tb_cond_select_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_select_pipe.sv
// rtl/cond_select_pipe.sv - priority condition-flag encoder feeding a 2-entry valid/ready buffer
// Multi-hot detection, out_multi and err_count are built only when COND_SELECT_MULTIHOT_CHECK_EN is defined.
module cond_select_pipe #(
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_en,
  input  logic [NUM_SRC-1:0] in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_hit,
  output logic               out_multi,
  output logic [CNT_W-1:0]   err_count,
  input  logic               clr_err
);

  generate
    if (NUM_SRC < 2 || (2 ** SEL_W) < NUM_SRC) begin : g_bad_params
      $error("cond_select_pipe: need NUM_SRC >= 2 and 2**SEL_W >= NUM_SRC");
    end
  endgenerate

  logic [SEL_W-1:0] enc_sel;
  logic             enc_hit;
  logic             enc_multi;

  // Descending scan so the lowest set flag wins.
  always_comb begin
    enc_sel = SEL_W'(DEFAULT_SEL);
    enc_hit = 1'b0;
    if (in_en) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (in_flags[i]) begin
          enc_sel = SEL_W'(i);
          enc_hit = 1'b1;
        end
      end
    end
  end

`ifdef COND_SELECT_MULTIHOT_CHECK_EN
  assign enc_multi = in_en && ((in_flags & (in_flags - NUM_SRC'(1))) != '0);
`else
  assign enc_multi = 1'b0;
`endif

  logic             push;
  logic             pop;
  logic             skid_valid;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_hit;
  logic             skid_multi;
  logic [1:0]       occ_next;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_next = 2'(out_valid) + 2'(skid_valid) + 2'(push) - 2'(pop);
  end

  // Head register drives the outputs directly; skid holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sel    <= '0;
      out_hit    <= 1'b0;
      out_multi  <= 1'b0;
      skid_valid <= 1'b0;
      skid_sel   <= '0;
      skid_hit   <= 1'b0;
      skid_multi <= 1'b0;
    end else begin
      in_ready <= (occ_next < 2'd2);
      if (skid_valid) begin
        // Full: in_ready is low, so only a pop can happen here.
        if (pop) begin
          out_sel    <= skid_sel;
          out_hit    <= skid_hit;
          out_multi  <= skid_multi;
          skid_valid <= 1'b0;
        end
      end else if (out_valid && !pop) begin
        if (push) begin
          skid_sel   <= enc_sel;
          skid_hit   <= enc_hit;
          skid_multi <= enc_multi;
          skid_valid <= 1'b1;
        end
      end else begin
        out_valid <= push;
        if (push) begin
          out_sel   <= enc_sel;
          out_hit   <= enc_hit;
          out_multi <= enc_multi;
        end
      end
    end
  end

`ifdef COND_SELECT_MULTIHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (push && enc_multi && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_cond_select_pipe.sv
// tb/tb_cond_select_pipe.sv - randomized and directed checks of cond_select_pipe against a queue model
// Expectations follow COND_SELECT_MULTIHOT_CHECK_EN when it is defined for the build.
module tb_cond_select_pipe;

`ifdef COND_SELECT_MULTIHOT_CHECK_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_en = 1'b0;
  logic [3:0] in_flags = 4'd0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;

  wire        in_ready, out_valid, out_hit, out_multi;
  wire [1:0]  out_sel;
  wire [7:0]  err_count;
  wire        in_ready2, out_valid2, out_hit2, out_multi2;
  wire [1:0]  out_sel2;
  wire [1:0]  err_count2;

  cond_select_pipe #(.NUM_SRC(4), .SEL_W(2), .DEFAULT_SEL(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_en(in_en),
    .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_hit(out_hit), .out_multi(out_multi), .err_count(err_count), .clr_err(clr_err));

  cond_select_pipe #(.NUM_SRC(4), .SEL_W(2), .DEFAULT_SEL(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_en(in_en),
    .in_flags(in_flags), .out_valid(out_valid2), .out_ready(out_ready), .out_sel(out_sel2),
    .out_hit(out_hit2), .out_multi(out_multi2), .err_count(err_count2), .clr_err(clr_err));

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [1:0] sel;
    logic       hit;
    logic       multi;
  } ent_t;

  ent_t q[$];
  ent_t last = '0;
  ent_t m_new;
  ent_t head;
  bit   m_rdy = 1'b0;
  bit   m_push, m_pop;
  int   m_err = 0;
  int   m_err2 = 0;

  function automatic ent_t encode(input logic en, input logic [3:0] f);
    ent_t e;
    logic [3:0] low;
    e = '0;
    if (en && f != 4'd0) begin
      low     = f & (~f + 4'd1);
      e.sel   = 2'($clog2(low));
      e.hit   = 1'b1;
      e.multi = MH && ($countones(f) >= 2);
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last   = '0;
      m_rdy  = 1'b0;
      m_err  = 0;
      m_err2 = 0;
    end else begin
      m_push = in_valid && m_rdy;
      m_pop  = (q.size() > 0) && out_ready;
      m_new  = encode(in_en, in_flags);
      if (m_pop) last = q.pop_front();
      if (m_push) q.push_back(m_new);
      if (MH && clr_err) begin
        m_err  = 0;
        m_err2 = 0;
      end else if (m_push && m_new.multi) begin
        m_err  = (m_err < 255) ? m_err + 1 : 255;
        m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
      end
      m_rdy = q.size() < 2;
    end
  end

  always @(negedge clk) begin
    head = (q.size() > 0) ? q[0] : last;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_sel", out_sel, head.sel);
    chk("out_hit", out_hit, head.hit);
    chk("out_multi", out_multi, head.multi);
    chk("err_count", err_count, m_err);
    chk("err_count_w2", err_count2, m_err2);
  end

  task automatic send(input logic en, input logic [3:0] f);
    in_valid = 1'b1;
    in_en    = en;
    in_flags = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    send(1'b1, 4'b0100);
    chk("pri_0100_sel", out_sel, 2);
    chk("pri_0100_hit", out_hit, 1);
    send(1'b1, 4'b0001);
    chk("pri_0001_sel", out_sel, 0);
    send(1'b1, 4'b1000);
    chk("pri_1000_sel", out_sel, 3);
    send(1'b0, 4'b0010);
    chk("dis_sel", out_sel, 0);
    chk("dis_hit", out_hit, 0);
    chk("dis_multi", out_multi, 0);
    send(1'b1, 4'b0000);
    chk("zero_hit", out_hit, 0);
    chk("zero_valid", out_valid, 1);
    send(1'b1, 4'b0110);
    chk("multi_sel", out_sel, 1);
    chk("multi_flag", out_multi, MH);
    chk("multi_err", err_count, MH ? 1 : 0);
    clr_err = 1'b1;
    send(1'b1, 4'b0110);
    clr_err = 1'b0;
    chk("clr_priority", err_count, 0);
    @(negedge clk);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_en     = 1'b1;
    in_flags  = 4'b0001;
    @(negedge clk);
    chk("bp_rdy1", in_ready, 1);
    chk("bp_head1", out_sel, 0);
    in_flags = 4'b0010;
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    in_flags = 4'b0100;
    @(negedge clk);
    chk("bp_hold_sel", out_sel, 0);
    chk("bp_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop1", out_sel, 1);
    chk("bp_reopen", in_ready, 1);
    @(negedge clk);
    chk("bp_third", out_sel, 2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_flags  = 4'b1000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_sel", out_sel, 0);
    chk("mid_rdy", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_rdy", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);

    out_ready = 1'b1;
    repeat (5) send(1'b1, 4'b0011);
    chk("sat_w2", err_count2, MH ? 3 : 0);
    chk("sat_w8", err_count, MH ? 5 : 0);
    send(1'b1, 4'b1111);
    chk("all_sel", out_sel, 0);
    chk("all_multi", out_multi, MH);

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_en     = ($urandom_range(0, 3) != 0);
      in_flags  = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
